// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register for the pipelined MIPS core.
// Owns the PC, redirects on EX branches and ID jumps, and honours hazard-unit stalls.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] id_rs_data,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
    output logic [5:0]  id_opcode,
    output logic [5:0]  id_funct,
    output logic [31:0] fetch_count
);

    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [31:0] jumpTarget;
    logic [31:0] jrTarget;
    logic [31:0] branchTarget;
    logic        takeJump;
    logic        takeJr;

    // Redirect targets are forced word aligned so the PC can never go misaligned.
    always_comb begin
        pcPlus4      = pc + 32'd4;
        jumpTarget   = {id_pc_plus4[31:28], id_instr[25:0], 2'b00};
        jrTarget     = {id_rs_data[31:2], 2'b00};
        branchTarget = {ex_branch_target[31:2], 2'b00};
        takeJump     = id_valid && (pcsrc == 2'b01);
        takeJr       = id_valid && (pcsrc == 2'b10);
    end

    assign imem_addr = pc;
    assign id_opcode = id_instr[31:26];
    assign id_funct  = id_instr[5:0];

    // Branch beats stall beats ID jumps; any redirect discards this cycle's fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            id_instr    <= 32'h0;
            id_pc_plus4 <= 32'h0;
            id_valid    <= 1'b0;
            fetch_count <= 32'h0;
        end else if (ex_branch_taken) begin
            pc       <= branchTarget;
            id_instr <= 32'h0;
            id_valid <= 1'b0;
        end else if (stall) begin
            pc       <= pc;
            id_valid <= id_valid;
        end else if (takeJump) begin
            pc       <= jumpTarget;
            id_instr <= 32'h0;
            id_valid <= 1'b0;
        end else if (takeJr) begin
            pc       <= jrTarget;
            id_instr <= 32'h0;
            id_valid <= 1'b0;
        end else begin
            pc          <= pcPlus4;
            id_instr    <= imem_rdata;
            id_pc_plus4 <= pcPlus4;
            id_valid    <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a reference model pushes expected IF/ID state
// into a scoreboard each cycle, and every scenario pops and compares after the edge.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic [1:0]  pcsrc;
    logic [31:0] id_rs_data;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [31:0] fetch_count;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] count;
    } expT;

    expT expQ[$];
    int total = 0;
    int bad = 0;

    logic [31:0] mPc, mInstr, mPc4, mCount;
    logic        mValid;

    fetch_stage #(.RESET_PC(32'h0040_0000)) dut (
        .clk(clk),
        .reset(reset),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .stall(stall),
        .pcsrc(pcsrc),
        .id_rs_data(id_rs_data),
        .ex_branch_taken(ex_branch_taken),
        .ex_branch_target(ex_branch_target),
        .id_instr(id_instr),
        .id_pc_plus4(id_pc_plus4),
        .id_valid(id_valid),
        .id_opcode(id_opcode),
        .id_funct(id_funct),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: a j 0x00400040 at 0x00400004, otherwise an address-tagged word.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0040_0004) return 32'h0810_0010;
        return {8'h20, a[23:0]};
    endfunction

    assign imem_rdata = memWord(imem_addr);

    // Reference model: predict the state after the coming edge from the current inputs.
    task automatic modelStep;
        expT e;
        logic [31:0] rd;
        rd = memWord(mPc);
        if (reset) begin
            mPc = 32'h0040_0000; mInstr = 0; mPc4 = 0; mValid = 0; mCount = 0;
        end else if (ex_branch_taken) begin
            mPc = {ex_branch_target[31:2], 2'b00}; mInstr = 0; mValid = 0;
        end else if (stall) begin
            mPc = mPc;
        end else if (mValid && pcsrc == 2'b01) begin
            mPc = {mPc4[31:28], mInstr[25:0], 2'b00}; mInstr = 0; mValid = 0;
        end else if (mValid && pcsrc == 2'b10) begin
            mPc = {id_rs_data[31:2], 2'b00}; mInstr = 0; mValid = 0;
        end else begin
            mInstr = rd; mPc4 = mPc + 32'd4; mPc = mPc + 32'd4; mValid = 1; mCount = mCount + 1;
        end
        e.addr = mPc; e.instr = mInstr; e.pc4 = mPc4; e.valid = mValid; e.count = mCount;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus;
        modelStep();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        expT e;
        reset = 1;
        applyStimulus();
        reset = 0;
        e = expQ.pop_front();
        total++;
        if ({imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count} !== {e.addr, e.instr, e.pc4, e.valid, e.count}) begin
            bad++;
            $display("[TB] FAIL reset_sb got=%h exp=%h", {imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count}, {e.addr, e.instr, e.pc4, e.valid, e.count});
        end
        total++;
        if ({imem_addr, id_valid} !== {32'h0040_0000, 1'b0}) begin
            bad++;
            $display("[TB] FAIL reset_const got=%h/%b exp=00400000/0", imem_addr, id_valid);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            e = expQ.pop_front();
            total++;
            if ({imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count} !== {e.addr, e.instr, e.pc4, e.valid, e.count}) begin
                bad++;
                $display("[TB] FAIL seq_sb%0d got=%h exp=%h", i, {imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count}, {e.addr, e.instr, e.pc4, e.valid, e.count});
            end
        end
        total++;
        if ({imem_addr, id_pc_plus4, fetch_count} !== {32'h0040_000C, 32'h0040_000C, 32'd3}) begin
            bad++;
            $display("[TB] FAIL seq_const got=%h %h %0d exp=0040000c 0040000c 3", imem_addr, id_pc_plus4, fetch_count);
        end
    endtask

    task automatic test_jump;
        expT e;
        reset = 1;
        applyStimulus();
        reset = 0;
        void'(expQ.pop_front());
        for (int i = 0; i < 2; i++) begin
            applyStimulus();
            void'(expQ.pop_front());
        end
        total++;
        if ({id_instr, id_pc_plus4, id_opcode, id_funct} !== {32'h0810_0010, 32'h0040_0008, 6'h02, 6'h10}) begin
            bad++;
            $display("[TB] FAIL jump_setup got=%h %h %h %h exp=08100010 00400008 02 10", id_instr, id_pc_plus4, id_opcode, id_funct);
        end
        pcsrc = 2'b01;
        applyStimulus();
        pcsrc = 2'b00;
        e = expQ.pop_front();
        total++;
        if ({imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count} !== {e.addr, e.instr, e.pc4, e.valid, e.count}) begin
            bad++;
            $display("[TB] FAIL jump_sb got=%h exp=%h", {imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count}, {e.addr, e.instr, e.pc4, e.valid, e.count});
        end
        total++;
        if ({imem_addr, id_valid, fetch_count} !== {32'h0040_0040, 1'b0, 32'd2}) begin
            bad++;
            $display("[TB] FAIL jump_const got=%h %b %0d exp=00400040 0 2", imem_addr, id_valid, fetch_count);
        end
        applyStimulus();
        e = expQ.pop_front();
        total++;
        if ({imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count} !== {32'h0040_0044, 32'h2040_0040, 32'h0040_0044, 1'b1, 32'd3}) begin
            bad++;
            $display("[TB] FAIL jump_resume got=%h exp=%h", {imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count}, {e.addr, e.instr, e.pc4, e.valid, e.count});
        end
    endtask

    task automatic test_jr;
        expT e;
        pcsrc = 2'b10;
        id_rs_data = 32'h0040_0103;
        applyStimulus();
        e = expQ.pop_front();
        total++;
        if ({imem_addr, id_instr, id_valid} !== {32'h0040_0100, 32'h0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL jr_const got=%h %h %b exp=00400100 00000000 0", imem_addr, id_instr, id_valid);
        end
        // pcsrc must be ignored while IF/ID holds a bubble
        pcsrc = 2'b01;
        applyStimulus();
        pcsrc = 2'b00;
        e = expQ.pop_front();
        total++;
        if ({imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count} !== {e.addr, e.instr, e.pc4, e.valid, e.count}) begin
            bad++;
            $display("[TB] FAIL jr_bubble_sb got=%h exp=%h", {imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count}, {e.addr, e.instr, e.pc4, e.valid, e.count});
        end
        total++;
        if ({imem_addr, id_valid} !== {32'h0040_0104, 1'b1}) begin
            bad++;
            $display("[TB] FAIL jr_bubble_const got=%h %b exp=00400104 1", imem_addr, id_valid);
        end
    endtask

    task automatic test_stall;
        expT e;
        logic [31:0] sAddr, sInstr, sCount;
        sAddr = mPc; sInstr = mInstr; sCount = mCount;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) pcsrc = 2'b01;
            applyStimulus();
            e = expQ.pop_front();
            total++;
            if ({imem_addr, id_instr, fetch_count} !== {sAddr, sInstr, sCount}) begin
                bad++;
                $display("[TB] FAIL stall_hold%0d got=%h %h %0d exp=%h %h %0d", i, imem_addr, id_instr, fetch_count, sAddr, sInstr, sCount);
            end
        end
        stall = 0;
        applyStimulus();
        pcsrc = 2'b00;
        e = expQ.pop_front();
        total++;
        if ({imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count} !== {e.addr, e.instr, e.pc4, e.valid, e.count}) begin
            bad++;
            $display("[TB] FAIL stall_jump_sb got=%h exp=%h", {imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count}, {e.addr, e.instr, e.pc4, e.valid, e.count});
        end
        total++;
        if (id_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stall_jump_valid got=%b exp=0", id_valid);
        end
        applyStimulus();
        e = expQ.pop_front();
        total++;
        if ({imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count} !== {e.addr, e.instr, e.pc4, e.valid, e.count}) begin
            bad++;
            $display("[TB] FAIL stall_resume_sb got=%h exp=%h", {imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count}, {e.addr, e.instr, e.pc4, e.valid, e.count});
        end
    endtask

    task automatic test_branch;
        expT e;
        logic [31:0] sCount;
        sCount = mCount;
        ex_branch_taken = 1;
        ex_branch_target = 32'h0040_0200;
        stall = 1;
        pcsrc = 2'b01;
        applyStimulus();
        stall = 0;
        pcsrc = 2'b00;
        ex_branch_target = 32'h0040_0307;
        e = expQ.pop_front();
        total++;
        if ({imem_addr, id_valid, id_instr, fetch_count} !== {32'h0040_0200, 1'b0, 32'h0, sCount}) begin
            bad++;
            $display("[TB] FAIL branch_const got=%h %b %h %0d exp=00400200 0 00000000 %0d", imem_addr, id_valid, id_instr, fetch_count, sCount);
        end
        applyStimulus();
        ex_branch_taken = 0;
        e = expQ.pop_front();
        total++;
        if ({imem_addr, id_valid} !== {32'h0040_0304, 1'b0}) begin
            bad++;
            $display("[TB] FAIL branch_align got=%h %b exp=00400304 0", imem_addr, id_valid);
        end
        applyStimulus();
        e = expQ.pop_front();
        total++;
        if ({imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count} !== {e.addr, e.instr, e.pc4, e.valid, e.count}) begin
            bad++;
            $display("[TB] FAIL branch_resume_sb got=%h exp=%h", {imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count}, {e.addr, e.instr, e.pc4, e.valid, e.count});
        end
    endtask

    task automatic test_wrap;
        expT e;
        pcsrc = 2'b10;
        id_rs_data = 32'hFFFF_FFFF;
        applyStimulus();
        pcsrc = 2'b00;
        e = expQ.pop_front();
        total++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            bad++;
            $display("[TB] FAIL wrap_jr got=%h exp=fffffffc", imem_addr);
        end
        applyStimulus();
        e = expQ.pop_front();
        total++;
        if ({imem_addr, id_pc_plus4, id_valid, id_instr} !== {32'h0, 32'h0, 1'b1, 32'h20FF_FFFC}) begin
            bad++;
            $display("[TB] FAIL wrap_const got=%h %h %b %h exp=00000000 00000000 1 20fffffc", imem_addr, id_pc_plus4, id_valid, id_instr);
        end
        total++;
        if ({imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count} !== {e.addr, e.instr, e.pc4, e.valid, e.count}) begin
            bad++;
            $display("[TB] FAIL wrap_sb got=%h exp=%h", {imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count}, {e.addr, e.instr, e.pc4, e.valid, e.count});
        end
    endtask

    task automatic test_reset_mid;
        pcsrc = 2'b01;
        stall = 1;
        reset = 1;
        applyStimulus();
        reset = 0;
        stall = 0;
        pcsrc = 2'b00;
        void'(expQ.pop_front());
        total++;
        if ({imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count} !== {32'h0040_0000, 32'h0, 32'h0, 1'b0, 32'h0}) begin
            bad++;
            $display("[TB] FAIL reset_mid got=%h %h %h %b %0d exp=00400000 0 0 0 0", imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count);
        end
    endtask

    initial begin
        reset = 1; stall = 0; pcsrc = 2'b00; id_rs_data = 32'h0;
        ex_branch_taken = 0; ex_branch_target = 32'h0;
        mPc = 0; mInstr = 0; mPc4 = 0; mValid = 0; mCount = 0;
        @(negedge clk);
        test_reset();
        test_jump();
        test_jr();
        test_stall();
        test_branch();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS core. It owns the program counter, drives the instruction-memory address, and latches the fetched word into IF/ID. It presents the ID-stage opcode/funct fields to the control decoder and consumes the decoder's `PCSrc` result for j/jal/jr. EX-stage branch resolutions redirect it, and the hazard unit can stall it.

## Interface
- `RESET_PC`, 32'h0040_0000, PC value loaded on reset (word aligned).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_addr`  out  32  instruction-memory address; equals the PC register.
- `imem_rdata`  in  32  instruction word at `imem_addr`; combinational read, valid in the same cycle.
- `stall`  in  1  hazard-unit hold request for the PC and IF/ID.
- `pcsrc`  in  2  decoder result for the IF/ID instruction: 00 sequential, 01 j/jal, 10 jr, 11 reserved (treated as 00).
- `id_rs_data`  in  32  forwarded rs value, used as the jr target.
- `ex_branch_taken`  in  1  beq in EX resolved taken.
- `ex_branch_target`  in  32  branch target from EX.
- `id_instr`  out  32  IF/ID instruction word.
- `id_pc_plus4`  out  32  IF/ID PC+4.
- `id_valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `id_opcode`  out  6  `id_instr[31:26]`, combinational, to the decoder.
- `id_funct`  out  6  `id_instr[5:0]`, combinational, to the decoder.
- `fetch_count`  out  32  number of instructions loaded into IF/ID since reset.

## Operation
- State consists of `pc`, `id_instr`, `id_pc_plus4`, `id_valid` and `fetch_count`. All of these are registers; every other output is combinational from them.
- Bubble: `id_instr`=32'h0 (sll $0 nop), `id_pc_plus4` unchanged, `id_valid`=0.
- Jump target for pcsrc 01 is `{id_pc_plus4[31:28], id_instr[25:0], 2'b00}`.
- Jr target for pcsrc 10 is `{id_rs_data[31:2], 2'b00}`.
- Branch target is `{ex_branch_target[31:2], 2'b00}`. The PC is always word aligned.
- Per-cycle update when `reset`=0, evaluated in strict priority order:
  1. `ex_branch_taken`=1: `pc`←branch target; IF/ID←bubble. This overrides `stall`.
  2. `stall`=1: `pc`, IF/ID and `fetch_count` hold.
  3. `id_valid`=1 and `pcsrc`=01: `pc`←jump target; IF/ID←bubble.
  4. `id_valid`=1 and `pcsrc`=10: `pc`←jr target; IF/ID←bubble.
  5. Otherwise: `pc`←`pc`+4; `id_instr`←`imem_rdata`; `id_pc_plus4`←`pc`+4; `id_valid`←1; `fetch_count`←`fetch_count`+1.
- When `id_valid`=0, `pcsrc` is ignored.
- No delay slots. The sequential fetch in the redirect cycle is discarded.
- Flushing ID/EX on a taken branch is the hazard unit's job, not this block's.
- Arithmetic is modulo 2^32. PC+4 from 32'hFFFF_FFFC wraps to 0. `fetch_count` wraps to 0.

## Timing
- Reset values: `pc`=`RESET_PC`, `imem_addr`=`RESET_PC`, `id_instr`=0, `id_pc_plus4`=0, `id_valid`=0, `fetch_count`=0.
- Reset is synchronous and overrides every other input. Asserting it mid-operation discards any pending jump, branch or stall at the next edge.
- Latency:
  - The word at `imem_addr` in cycle N appears on `id_instr` in cycle N+1.
  - The decoder's `pcsrc` for that word is sampled at the end of cycle N+1.
- Penalties:
  - j/jal/jr cost 1 bubble. The target address is presented in cycle N+2.
  - A taken branch costs 2 fetched slots: the one in IF/ID is flushed here, the one in IF is discarded.
- If `ex_branch_taken` and an ID jump occur in the same cycle, the branch wins and the jump is squashed.
- If `stall` and an ID jump occur together, the jump is held and re-evaluated each cycle until `stall` drops.

## Test plan
- Reset with `RESET_PC`=32'h0040_0000, no stall:
  - Cycle 0: `imem_addr`=0x00400000, `id_valid`=0.
  - After 3 edges: `imem_addr`=0x0040000C, `id_pc_plus4`=0x0040000C, `fetch_count`=3.
- j: IF/ID holds 32'h0810_0010 at `id_pc_plus4`=0x00400008 with `pcsrc`=01.
  - Next cycle: `imem_addr`=0x00400040, `id_valid`=0, `fetch_count` unchanged.
- jr: `pcsrc`=10 and `id_rs_data`=0x00400103.
  - Next `imem_addr`=0x00400100, with IF/ID bubbled.
- `stall`=1 for 3 cycles: `imem_addr`, `id_instr` and `fetch_count` stay constant; fetch resumes the cycle after release.
- Taken branch with simultaneous stall and `pcsrc`=01: `ex_branch_taken`=1, `ex_branch_target`=0x00400200, `stall`=1.
  - Next `imem_addr`=0x00400200, `id_valid`=0; the jump is ignored.
- Wrap and reset:
  - With PC at 32'hFFFF_FFFC, the next PC is 0 and `id_pc_plus4`=0.
  - `reset` asserted during a pending jump restores all reset values at the next edge.
